// File: rtl/branch_sequencer.sv
// Program-counter sequencer and requester side of the branch-unit handshake.
// Steps the instruction count by one, or runs a CLEAR/REQ exchange with the
// branch unit on a taken branch and loads its target, faulting on reject/timeout.
module branch_sequencer #(
  parameter int unsigned       SIZE     = 8,
  parameter int unsigned       TIMEOUT  = 16,
  parameter logic [SIZE-1:0]   RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            step,
  input  logic            isBranch,
  input  logic            branchTaken,
  input  logic [2:0]      offset,
  output logic [SIZE-1:0] currentCount,
  output logic            busy,
  output logic            stepDone,
  output logic            branchFault,
  output logic            branchReset,
  output logic            branchEnable,
  output logic            branchControl,
  output logic [2:0]      programNum,
  input  logic [SIZE-1:0] branchResult,
  input  logic            branchDone
);

  // Timeout counter counts REQ sampling edges 0..TIMEOUT-1.
  localparam int unsigned TW    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    REQ   = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [TW-1:0]   tcnt, tcnt_n;
  logic [SIZE-1:0] count_n;
  logic            fault_n;
  logic            done_n;
  logic [2:0]      pn_n;
  logic            busy_n;
  logic            breset_n;
  logic            enable_n;

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_n  = state;
    tcnt_n   = tcnt;
    count_n  = currentCount;
    fault_n  = branchFault;
    pn_n     = programNum;
    done_n   = 1'b0;

    unique case (state)
      IDLE: begin
        if (step) begin
          if (isBranch && branchTaken) begin
            pn_n    = offset;
            state_n = CLEAR;
          end else begin
            count_n = currentCount + SIZE'(1);
            done_n  = 1'b1;
          end
        end
      end

      // branchDone may be stale from the previous request, so it is ignored here.
      CLEAR: begin
        tcnt_n  = '0;
        state_n = REQ;
      end

      REQ: begin
        if (branchDone) begin
          // A nonzero offset that yields the current count means the unit refused it.
          if ((programNum != 3'd0) && (branchResult == currentCount)) begin
            count_n = currentCount + SIZE'(1);
            fault_n = 1'b1;
          end else begin
            count_n = branchResult;
          end
          done_n  = 1'b1;
          state_n = IDLE;
        end else if (tcnt == TLAST) begin
          count_n = currentCount + SIZE'(1);
          fault_n = 1'b1;
          done_n  = 1'b1;
          state_n = IDLE;
        end else begin
          tcnt_n = tcnt + TW'(1);
        end
      end

      default: state_n = IDLE;
    endcase

    busy_n   = (state_n != IDLE);
    breset_n = (state_n == CLEAR);
    enable_n = (state_n == REQ);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      tcnt          <= '0;
      currentCount  <= RESET_PC;
      busy          <= 1'b0;
      stepDone      <= 1'b0;
      branchFault   <= 1'b0;
      branchReset   <= 1'b0;
      branchEnable  <= 1'b0;
      branchControl <= 1'b0;
      programNum    <= 3'd0;
    end else begin
      state         <= state_n;
      tcnt          <= tcnt_n;
      currentCount  <= count_n;
      busy          <= busy_n;
      stepDone      <= done_n;
      branchFault   <= fault_n;
      branchReset   <= breset_n;
      branchEnable  <= enable_n;
      branchControl <= enable_n;
      programNum    <= pn_n;
    end
  end

endmodule

// File: tb/tb_branch_sequencer.sv
// Self-checking bench for branch_sequencer: transaction-age model plus directed vectors.
module tb_branch_sequencer;

  localparam int unsigned SIZE    = 8;
  localparam int unsigned TIMEOUT = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic            step;
  logic            isBranch;
  logic            branchTaken;
  logic [2:0]      offset;
  logic [SIZE-1:0] currentCount;
  logic            busy;
  logic            stepDone;
  logic            branchFault;
  logic            branchReset;
  logic            branchEnable;
  logic            branchControl;
  logic [2:0]      programNum;
  logic [SIZE-1:0] branchResult;
  logic            branchDone;

  int checks = 0;
  int errors = 0;

  branch_sequencer #(.SIZE(SIZE), .TIMEOUT(TIMEOUT), .RESET_PC(8'd0)) dut (
    .clk(clk), .reset(reset), .step(step), .isBranch(isBranch),
    .branchTaken(branchTaken), .offset(offset), .currentCount(currentCount),
    .busy(busy), .stepDone(stepDone), .branchFault(branchFault),
    .branchReset(branchReset), .branchEnable(branchEnable),
    .branchControl(branchControl), .programNum(programNum),
    .branchResult(branchResult), .branchDone(branchDone)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: m_age counts edges since a taken branch was accepted (0 = no branch in flight).
  logic [SIZE-1:0] m_count;
  logic            m_fault, m_sd;
  logic [2:0]      m_pn;
  int              m_age;
  bit              m_started = 1'b0;

  always @(posedge clk) begin
    m_started = 1'b1;
    if (reset) begin
      m_count = 8'd0; m_fault = 1'b0; m_sd = 1'b0; m_pn = 3'd0; m_age = 0;
    end else begin
      m_sd = 1'b0;
      if (m_age == 0) begin
        if (step) begin
          if (isBranch && branchTaken) begin
            m_pn = offset; m_age = 1;
          end else begin
            m_count = m_count + 8'd1; m_sd = 1'b1;
          end
        end
      end else if (m_age == 1) begin
        m_age = 2;
      end else begin
        if (branchDone) begin
          if (m_pn != 3'd0 && branchResult == m_count) begin
            m_count = m_count + 8'd1; m_fault = 1'b1;
          end else begin
            m_count = branchResult;
          end
          m_sd = 1'b1; m_age = 0;
        end else if (m_age - 1 == TIMEOUT) begin
          m_count = m_count + 8'd1; m_fault = 1'b1; m_sd = 1'b1; m_age = 0;
        end else begin
          m_age = m_age + 1;
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_started) begin
      cmp("m_currentCount",  32'(currentCount),  32'(m_count));
      cmp("m_stepDone",      32'(stepDone),      32'(m_sd));
      cmp("m_branchFault",   32'(branchFault),   32'(m_fault));
      cmp("m_busy",          32'(busy),          32'(m_age != 0));
      cmp("m_branchReset",   32'(branchReset),   32'(m_age == 1));
      cmp("m_branchEnable",  32'(branchEnable),  32'(m_age >= 2));
      cmp("m_branchControl", 32'(branchControl), 32'(m_age >= 2));
      cmp("m_programNum",    32'(programNum),    32'(m_pn));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic plain_steps(input int n);
    step = 1'b1; isBranch = 1'b0; branchTaken = 1'b0;
    tick(n);
    step = 1'b0;
  endtask

  task automatic take_branch(input logic [2:0] off);
    step = 1'b1; isBranch = 1'b1; branchTaken = 1'b1; offset = off;
    tick(1);
    step = 1'b0; isBranch = 1'b0; branchTaken = 1'b0;
  endtask

  initial begin
    reset = 1'b1; step = 1'b0; isBranch = 1'b0; branchTaken = 1'b0;
    offset = 3'd0; branchResult = 8'd0; branchDone = 1'b0;
    tick(2);
    cmp("reset_count", 32'(currentCount), 32'd0);
    cmp("reset_busy",  32'(busy), 32'd0);
    cmp("reset_sd",    32'(stepDone), 32'd0);
    reset = 1'b0;

    // Three back-to-back plain steps.
    step = 1'b1;
    tick(1); cmp("step1", 32'(currentCount), 32'd1); cmp("step1_sd", 32'(stepDone), 32'd1);
    tick(1); cmp("step2", 32'(currentCount), 32'd2);
    tick(1); cmp("step3", 32'(currentCount), 32'd3);
    step = 1'b0;
    tick(1); cmp("idle_sd", 32'(stepDone), 32'd0);

    // Wrap all-ones to zero.
    plain_steps(252); cmp("to_ff", 32'(currentCount), 32'hFF);
    plain_steps(1);   cmp("wrap", 32'(currentCount), 32'h00);

    // Taken branch at 10, offset -3, target 7.
    plain_steps(10);
    take_branch(3'b101);
    cmp("br_reset", 32'(branchReset), 32'd1);
    cmp("br_busy",  32'(busy), 32'd1);
    cmp("br_pn",    32'(programNum), 32'd5);
    cmp("br_en_clear", 32'(branchEnable), 32'd0);
    tick(1);
    cmp("br_en",  32'(branchEnable), 32'd1);
    cmp("br_ctl", 32'(branchControl), 32'd1);
    cmp("br_reset_off", 32'(branchReset), 32'd0);
    tick(1);
    branchDone = 1'b1; branchResult = 8'd7;
    tick(1);
    cmp("br_count", 32'(currentCount), 32'd7);
    cmp("br_sd",    32'(stepDone), 32'd1);
    cmp("br_idle",  32'(busy), 32'd0);
    cmp("br_fault", 32'(branchFault), 32'd0);
    branchDone = 1'b0;
    tick(1); cmp("br_sd_once", 32'(stepDone), 32'd0);

    // Not-taken branch at 20.
    plain_steps(13);
    step = 1'b1; isBranch = 1'b1; branchTaken = 1'b0;
    tick(1);
    step = 1'b0; isBranch = 1'b0;
    cmp("nt_count", 32'(currentCount), 32'd21);
    cmp("nt_breset", 32'(branchReset), 32'd0);
    tick(1); cmp("nt_en", 32'(branchEnable), 32'd0);

    // Offset 0 taken: self-loop, no fault.
    take_branch(3'b000);
    tick(1);
    branchDone = 1'b1; branchResult = 8'd21;
    tick(1);
    cmp("self_count", 32'(currentCount), 32'd21);
    cmp("self_fault", 32'(branchFault), 32'd0);
    branchDone = 1'b0;

    // Rejected branch at 1, offset -2; done held from the start of the request.
    plain_steps(236); cmp("to_one", 32'(currentCount), 32'd1);
    branchDone = 1'b1; branchResult = 8'd1;
    take_branch(3'b110);
    tick(1); cmp("rej_busy", 32'(busy), 32'd1);
    tick(1);
    cmp("rej_count", 32'(currentCount), 32'd2);
    cmp("rej_fault", 32'(branchFault), 32'd1);
    branchDone = 1'b0;
    plain_steps(2);
    cmp("rej_after", 32'(currentCount), 32'd4);
    cmp("rej_sticky", 32'(branchFault), 32'd1);

    // Timeout, with a stale done held through CLEAR.
    branchDone = 1'b1; branchResult = 8'h99;
    take_branch(3'b001);
    tick(1);
    cmp("to_en", 32'(branchEnable), 32'd1);
    branchDone = 1'b0;
    tick(TIMEOUT - 1);
    cmp("to_wait_busy",  32'(busy), 32'd1);
    cmp("to_wait_count", 32'(currentCount), 32'd4);
    tick(1);
    cmp("to_busy",  32'(busy), 32'd0);
    cmp("to_count", 32'(currentCount), 32'd5);
    cmp("to_sd",    32'(stepDone), 32'd1);

    // branchDone on the timeout edge wins.
    take_branch(3'b010);
    tick(1);
    tick(TIMEOUT - 1);
    branchDone = 1'b1; branchResult = 8'd50;
    tick(1);
    cmp("race_count", 32'(currentCount), 32'd50);
    branchDone = 1'b0;

    // Step while busy is ignored; reset in REQ discards the branch.
    take_branch(3'b011);
    step = 1'b1;
    tick(3);
    cmp("busy_ignore", 32'(currentCount), 32'd50);
    step = 1'b0;
    reset = 1'b1;
    tick(1);
    cmp("mid_count", 32'(currentCount), 32'd0);
    cmp("mid_fault", 32'(branchFault), 32'd0);
    cmp("mid_busy",  32'(busy), 32'd0);
    cmp("mid_en",    32'(branchEnable), 32'd0);
    cmp("mid_pn",    32'(programNum), 32'd0);
    reset = 1'b0;
    tick(1);
    plain_steps(1);
    cmp("post_reset_step", 32'(currentCount), 32'd1);
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
